// File: rtl/leading_bits_stream.sv
// Counts leading BIT-valued bits of a multi-beat message and reports count, all-match and saturation.
// Result valid 1 cycle after the last-beat handshake; in_ready drops while an unconsumed result is held.
module leading_bits_stream #(
  parameter int   WIDTH       = 12,
  parameter logic BIT         = 1'b1,
  parameter int   COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:WIDTH-1]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_all,
  output logic                   out_saturated
);

  localparam int LW = $clog2(WIDTH + 1);
  localparam int SW = ((COUNT_WIDTH > LW) ? COUNT_WIDTH : LW) + 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {COUNT, SKIP} state_t;

  typedef struct packed {
    logic [COUNT_WIDTH-1:0] count;
    logic                   all;
    logic                   sat;
  } acc_t;

  localparam acc_t ACC_INIT = '{count: '0, all: 1'b1, sat: 1'b0};

  state_t         state_q, state_d;
  acc_t           acc_q, acc_d, cur;
  acc_t           res_q, res_d;
  logic           out_valid_d;
  logic [LW-1:0]  lead;
  logic           run;
  logic           beat_all;
  logic           accept;
  logic [SW-1:0]  sum;

  assign in_ready      = !out_valid || out_ready;
  assign accept        = in_valid && in_ready;
  assign out_count     = res_q.count;
  assign out_all       = res_q.all;
  assign out_saturated = res_q.sat;

  // Leading-BIT run length of the current beat, scanning from index 0.
  always_comb begin
    lead = '0;
    run  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (run && (in_data[i] == BIT)) begin
        lead = lead + LW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  assign beat_all = (lead == LW'(WIDTH));
  assign sum      = SW'(acc_q.count) + SW'(lead);

  // Accumulator as it would stand after absorbing this beat; SKIP contributes nothing.
  always_comb begin
    cur = acc_q;
    if (state_q == COUNT) begin
      if (acc_q.sat || (sum > SW'(CNT_MAX))) begin
        cur.count = CNT_MAX;
        cur.sat   = 1'b1;
      end else begin
        cur.count = sum[COUNT_WIDTH-1:0];
      end
      cur.all = acc_q.all && beat_all;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    res_d       = res_q;
    out_valid_d = out_valid;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (in_last) begin
        res_d       = cur;
        out_valid_d = 1'b1;
        acc_d       = ACC_INIT;
        state_d     = COUNT;
      end else begin
        acc_d = cur;
        if ((state_q == COUNT) && !beat_all) begin
          state_d = SKIP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= COUNT;
      acc_q     <= ACC_INIT;
      res_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: doc/leading_bits_stream.md
LEADING_BITS_STREAM -- requirements
Module: leading_bits_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 12, bits per input beat (>=1).
REQ-002 SHALL have parameter BIT, default 1'b1, bit value being counted.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, result width (>=1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  input beat accepted when in_valid and in_ready are both 1.
REQ-008 SHALL have port in_data  input  [0:WIDTH-1]  beat data; index 0 is the leading (first-scanned) bit.
REQ-009 SHALL have port in_last  input  1  marks the final beat of a message.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid and out_ready are both 1.
REQ-012 SHALL have port out_count  output  [COUNT_WIDTH-1:0]  leading-BIT count of the message.
REQ-013 SHALL have port out_all  output  1  every bit of the message equalled BIT.
REQ-014 SHALL have port out_saturated  output  1  true count exceeded 2^COUNT_WIDTH-1.

Function
REQ-015 SHALL define a message as consecutive accepted beats up to and including a beat with in_last=1.
REQ-016 SHALL count BIT-valued bits from in_data[0] of the first beat, continuing across beats in order, until the first non-BIT bit.
REQ-017 SHALL have states COUNT (reset/message start) and SKIP (mismatch seen, message unfinished).
REQ-018 SHALL, in COUNT, on an accepted beat with all bits == BIT, add WIDTH to the accumulator and stay in COUNT.
REQ-019 SHALL, in COUNT, on an accepted beat with a mismatch, add that beat's leading-BIT count (0..WIDTH-1), clear the all-flag, and go to SKIP unless in_last.
REQ-020 SHALL, in SKIP, consume beats without changing accumulator or flags.
REQ-021 SHALL, on acceptance of an in_last beat in either state, load out_count/out_all/out_saturated including that beat's contribution, set out_valid the next cycle, clear the accumulator, set the all-flag, and return to COUNT.
REQ-022 SHALL saturate the accumulator at 2^COUNT_WIDTH-1 and set the saturated flag; further additions leave it saturated.
REQ-023 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-024 SHALL keep out_count/out_all/out_saturated stable while out_valid=1 and out_ready=0.
REQ-025 SHALL clear out_valid after the handshake unless a new result loads in the same cycle.
REQ-026 SHALL have latency exactly 1 cycle from the last-beat handshake to out_valid=1; throughput one beat per cycle when out_ready=1.
REQ-027 SHALL ignore in_data/in_last when in_valid=0.

Reset
REQ-028 SHALL, when resetn=0 at a clock edge, set state=COUNT, accumulator=0, all-flag=1, saturated flag=0, out_valid=0, out_count=0, out_all=0, out_saturated=0.
REQ-029 SHALL discard any partially received message on reset.

Verification
REQ-030 SHALL test: single beat, in_data[0:2]=1 rest 0, in_last=1 -> next cycle out_valid=1, out_count=3, out_all=0, out_saturated=0.
REQ-031 SHALL test: beats all-ones, all-ones, then in_data[0:1]=1, [2]=0, [3:11]=1 with last -> out_count=26, out_all=0.
REQ-032 SHALL test: two all-ones beats, last on the second -> out_count=24, out_all=1; a single all-zeros beat with last -> out_count=0, out_all=0.
REQ-033 SHALL test COUNT_WIDTH=4: two all-ones beats with last -> out_count=15, out_saturated=1, out_all=1.
REQ-034 SHALL test: result pending with out_ready=0 -> in_ready=0 and outputs held; out_ready=1 -> first result popped, queued next message's last beat accepted the same cycle, its result valid the following cycle.
REQ-035 SHALL test: one all-ones beat (no last), resetn=0 for 1 cycle, then beat in_data[0]=1 rest 0 with last -> out_count=1, out_all=0.
